// File: rtl/ex_mem_arbiter.sv
// ex_mem_arbiter: shares the single data SRAM port between the two EX issue slots.
// Dual-memory bundle serialisation is built only when DUAL_MEM_ISSUE_EN is defined.
module ex_mem_arbiter #(
    localparam int unsigned STALL_W  = 6,
    localparam int unsigned STOP_BIT = 3,
    localparam int unsigned WEN_W    = 4,
    localparam int unsigned ADDR_W   = 32,
    localparam int unsigned DATA_W   = 32,
    localparam int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [STALL_W-1:0] stall,
    input  logic               s1_en,
    input  logic [WEN_W-1:0]   s1_wen,
    input  logic [ADDR_W-1:0]  s1_addr,
    input  logic [DATA_W-1:0]  s1_wdata,
    input  logic               s2_en,
    input  logic [WEN_W-1:0]   s2_wen,
    input  logic [ADDR_W-1:0]  s2_addr,
    input  logic [DATA_W-1:0]  s2_wdata,
    output logic               data_sram_en,
    output logic [WEN_W-1:0]   data_sram_wen,
    output logic [ADDR_W-1:0]  data_sram_addr,
    output logic [DATA_W-1:0]  data_sram_wdata,
    output logic               mem_slot_sel,
    output logic               stallreq_for_ex,
    output logic [CNT_W-1:0]   conflict_cnt
);

    localparam logic STOP = 1'b1;

    logic mem_stop;
    logic unused_stall_bits;

    assign mem_stop          = (stall[STOP_BIT] == STOP);
    assign unused_stall_bits = ^{stall[STALL_W-1:STOP_BIT+1], stall[STOP_BIT-1:0]};

`ifdef DUAL_MEM_ISSUE_EN

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [WEN_W-1:0]  wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    state_e             state_q, state_d;
    mem_req_t           hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: rst > flush > MEM stop > normal arbitration.
    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        cnt_d           = cnt_q;
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        mem_slot_sel    = 1'b0;
        stallreq_for_ex = 1'b0;
        conflict_cnt    = rst ? '0 : cnt_q;

        if (rst) begin
            state_d = IDLE;
        end else if (flush) begin
            state_d = IDLE;
            hold_d  = '0;
        end else if (mem_stop) begin
            // Held slot-2 op waits; keep ID/EX frozen until MEM can take it.
            stallreq_for_ex = (state_q == PEND);
        end else if (state_q == PEND) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = hold_q.wen;
            data_sram_addr  = hold_q.addr;
            data_sram_wdata = hold_q.wdata;
            mem_slot_sel    = 1'b1;
            state_d         = IDLE;
            hold_d          = '0;
        end else if (s1_en) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = s1_wen;
            data_sram_addr  = s1_addr;
            data_sram_wdata = s1_wdata;
            if (s2_en) begin
                hold_d          = '{wen: s2_wen, addr: s2_addr, wdata: s2_wdata};
                stallreq_for_ex = 1'b1;
                cnt_d           = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                state_d         = PEND;
            end
        end else if (s2_en) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = s2_wen;
            data_sram_addr  = s2_addr;
            data_sram_wdata = s2_wdata;
            mem_slot_sel    = 1'b1;
        end
    end

`else

    logic unused_inputs;

    assign unused_inputs = ^{clk, s2_en, s2_wen, s2_addr, s2_wdata};

    // Slot 1 only; ID guarantees no dual-memory bundles in this build.
    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        mem_slot_sel    = 1'b0;
        stallreq_for_ex = 1'b0;
        conflict_cnt    = '0;

        if (!rst && !flush && !mem_stop && s1_en) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = s1_wen;
            data_sram_addr  = s1_addr;
            data_sram_wdata = s1_wdata;
        end
    end

`endif

endmodule

// File: tb/tb_ex_mem_arbiter.sv
// tb_ex_mem_arbiter: directed scoreboard bench for ex_mem_arbiter.
// Expectations follow the DUAL_MEM_ISSUE_EN setting of the build.
module tb_ex_mem_arbiter;

`ifdef DUAL_MEM_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        sel;
        logic        stallreq;
        logic [31:0] cnt;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic        s1_en, s2_en;
    logic [3:0]  s1_wen, s2_wen;
    logic [31:0] s1_addr, s2_addr, s1_wdata, s2_wdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        mem_slot_sel, stallreq_for_ex;
    logic [31:0] conflict_cnt;

    int total = 0;
    int bad   = 0;

    obs_t  exp_q[$];
    string name_q[$];

    ex_mem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .stall           (stall),
        .s1_en           (s1_en),
        .s1_wen          (s1_wen),
        .s1_addr         (s1_addr),
        .s1_wdata        (s1_wdata),
        .s2_en           (s2_en),
        .s2_wen          (s2_wen),
        .s2_addr         (s2_addr),
        .s2_wdata        (s2_wdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .mem_slot_sel    (mem_slot_sel),
        .stallreq_for_ex (stallreq_for_ex),
        .conflict_cnt    (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic req_t rq(input logic [3:0] wen, input logic [31:0] addr,
                                input logic [31:0] wdata);
        return '{en: 1'b1, wen: wen, addr: addr, wdata: wdata};
    endfunction

    function automatic obs_t ob(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic sel, input logic st,
                                input logic [31:0] cnt);
        return '{en: en, wen: wen, addr: addr, wdata: wdata, sel: sel, stallreq: st, cnt: cnt};
    endfunction

    // Counter value as seen in this build (tied to 0 without the dual-issue feature).
    function automatic logic [31:0] ec(input logic [31:0] c);
        return DUAL ? c : 32'd0;
    endfunction

    localparam req_t NOREQ = '0;

    // One pipeline cycle: drive inputs just after the edge, queue that cycle's expectation.
    task automatic step(input string nm, input logic r, input logic f, input logic stop,
                        input req_t a, input req_t b, input obs_t e);
        @(posedge clk);
        #1;
        rst      = r;
        flush    = f;
        stall    = {2'b00, stop, 3'b000};
        s1_en    = a.en;  s1_wen = a.wen;  s1_addr = a.addr;  s1_wdata = a.wdata;
        s2_en    = b.en;  s2_wen = b.wen;  s2_addr = b.addr;  s2_wdata = b.wdata;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare every queued expectation mid-cycle, away from the active edge.
    always @(negedge clk) begin
        obs_t  got;
        obs_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                   mem_slot_sel, stallreq_for_ex, conflict_cnt};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got en=%b wen=%h addr=%h wdata=%h sel=%b st=%b cnt=%h | exp en=%b wen=%h addr=%h wdata=%h sel=%b st=%b cnt=%h",
                         nm, got.en, got.wen, got.addr, got.wdata, got.sel, got.stallreq, got.cnt,
                         e.en, e.wen, e.addr, e.wdata, e.sel, e.stallreq, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t st_a, ld_a, ld_b, st_b, st_c, st_d;
        rst = 1'b1; flush = 1'b0; stall = '0;
        s1_en = 1'b0; s1_wen = '0; s1_addr = '0; s1_wdata = '0;
        s2_en = 1'b0; s2_wen = '0; s2_addr = '0; s2_wdata = '0;

        st_a = rq(4'hF, 32'h0000_0020, 32'hAA55_AA55);
        ld_a = rq(4'h0, 32'h0000_0020, 32'h0);
        ld_b = rq(4'h0, 32'h0000_0100, 32'h0);
        st_b = rq(4'hF, 32'h0000_0104, 32'hCAFE_F00D);
        st_c = rq(4'h3, 32'h0000_0200, 32'h1111_2222);
        st_d = rq(4'hC, 32'h0000_0204, 32'h3333_4444);

        step("reset0", 1'b1, 1'b0, 1'b0, st_a, ld_a, '0);
        step("reset1", 1'b1, 1'b0, 1'b0, st_a, ld_a, '0);
        step("idle",   1'b0, 1'b0, 1'b0, NOREQ, NOREQ, '0);

        step("s2_load", 1'b0, 1'b0, 1'b0, NOREQ, rq(4'h0, 32'h1000, 32'h0),
             DUAL ? ob(1'b1, 4'h0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'd0) : obs_t'('0));
        step("s1_store", 1'b0, 1'b0, 1'b0, rq(4'h3, 32'h44, 32'h1234_5678), NOREQ,
             ob(1'b1, 4'h3, 32'h44, 32'h1234_5678, 1'b0, 1'b0, 32'd0));

`ifdef DUAL_MEM_ISSUE_EN
        step("dual_n",  1'b0, 1'b0, 1'b0, st_a, ld_a, ob(1'b1, 4'hF, 32'h20, 32'hAA55_AA55, 1'b0, 1'b1, 32'd0));
        step("dual_n1", 1'b0, 1'b0, 1'b0, st_a, ld_a, ob(1'b1, 4'h0, 32'h20, 32'h0, 1'b1, 1'b0, 32'd1));
        step("dual_after", 1'b0, 1'b0, 1'b0, NOREQ, NOREQ, ob(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd1));

        step("stop_n",   1'b0, 1'b0, 1'b0, ld_b, st_b, ob(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 32'd1));
        step("stop_p1",  1'b0, 1'b0, 1'b1, ld_b, st_b, ob(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd2));
        step("stop_p2",  1'b0, 1'b0, 1'b1, ld_b, st_b, ob(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd2));
        step("stop_go",  1'b0, 1'b0, 1'b0, ld_b, st_b, ob(1'b1, 4'hF, 32'h104, 32'hCAFE_F00D, 1'b1, 1'b0, 32'd2));
        step("stop_once", 1'b0, 1'b0, 1'b0, NOREQ, NOREQ, ob(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd2));

        step("flush_n",   1'b0, 1'b0, 1'b0, st_c, st_d, ob(1'b1, 4'h3, 32'h200, 32'h1111_2222, 1'b0, 1'b1, 32'd2));
        step("flush_n1",  1'b0, 1'b1, 1'b0, st_c, st_d, ob(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd3));
        step("flush_idle", 1'b0, 1'b0, 1'b0, NOREQ, NOREQ, ob(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd3));
`else
        step("dual_s1only", 1'b0, 1'b0, 1'b0, st_a, ld_a, ob(1'b1, 4'hF, 32'h20, 32'hAA55_AA55, 1'b0, 1'b0, 32'd0));
        step("dual_after",  1'b0, 1'b0, 1'b0, NOREQ, NOREQ, '0);
`endif

        step("idle_stop",  1'b0, 1'b0, 1'b1, st_c, st_d, ob(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, ec(32'd3)));
        step("idle_stop2", 1'b0, 1'b0, 1'b0, NOREQ, NOREQ, ob(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, ec(32'd3)));
        step("idle_flush", 1'b0, 1'b1, 1'b0, st_c, NOREQ, ob(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, ec(32'd3)));

`ifdef DUAL_MEM_ISSUE_EN
        // Preload the counter near saturation between edges.
        @(negedge clk);
        #2;
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        for (int k = 0; k < 3; k++) begin
            step("sat_n",  1'b0, 1'b0, 1'b0, st_c, st_d,
                 ob(1'b1, 4'h3, 32'h200, 32'h1111_2222, 1'b0, 1'b1, (k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF));
            step("sat_n1", 1'b0, 1'b0, 1'b0, st_c, st_d,
                 ob(1'b1, 4'hC, 32'h204, 32'h3333_4444, 1'b1, 1'b0, 32'hFFFF_FFFF));
        end
        step("sat_hold", 1'b0, 1'b0, 1'b0, NOREQ, NOREQ, ob(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF));
`endif

        step("reset_again", 1'b1, 1'b0, 1'b0, st_a, ld_a, '0);
        step("post_reset",  1'b0, 1'b0, 1'b0, NOREQ, NOREQ, '0);

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
